// File: rtl/bcd_display_if.sv
// Display driver bus: upstream units digit in, multiplexed 7-segment drive and status out.
interface bcd_display_if;
   logic [3:0] units_in;
   logic [6:0] seg;
   logic [1:0] an;
   logic [3:0] tens;
   logic       overflow;
   logic       invalid;

   modport master (output units_in, input seg, an, tens, overflow, invalid);
   modport slave  (input units_in, output seg, an, tens, overflow, invalid);
endinterface

// File: rtl/bcd_display_driver.sv
// Two-digit multiplexed 7-segment driver: tens counter from units wraps, sticky invalid flag.
// Optional LEADING_ZERO_BLANK_EN blanks the tens digit while it reads zero.
module bcd_display_driver #(
   parameter int SCAN_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   bcd_display_if.slave     bus
);
   localparam int PW = $clog2(SCAN_DIV) + 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   logic [PW-1:0] presc;
   logic          sel;
   logic [3:0]    units_prev;
   logic [3:0]    tens_q;
   logic [6:0]    seg_q;
   logic [1:0]    an_q;
   logic          overflow_q;
   logic          invalid_q;
   logic          wrap;
   logic [3:0]    digit;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   // Only a clean 9->0 step counts; out-of-range values never match either side.
   assign wrap  = (units_prev == 4'd9) && (bus.units_in == 4'd0);
   assign digit = sel ? tens_q : bus.units_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         presc      <= '0;
         sel        <= 1'b0;
         units_prev <= 4'd0;
         tens_q     <= 4'd0;
         seg_q      <= 7'h00;
         an_q       <= 2'b00;
         overflow_q <= 1'b0;
         invalid_q  <= 1'b0;
      end else begin
         units_prev <= bus.units_in;
         overflow_q <= 1'b0;
         if (wrap) begin
            if (tens_q == 4'd9) begin
               tens_q     <= 4'd0;
               overflow_q <= 1'b1;
            end else begin
               tens_q <= tens_q + 4'd1;
            end
         end
         if (bus.units_in > 4'd9)
            invalid_q <= 1'b1;

         if (presc == PRESC_LAST) begin
            presc <= '0;
            sel   <= ~sel;
         end else begin
            presc <= presc + PW'(1);
         end

         // Drive uses the slot and tens value from before this edge.
`ifdef LEADING_ZERO_BLANK_EN
         if (sel && tens_q == 4'd0) begin
            an_q  <= 2'b00;
            seg_q <= 7'h00;
         end else begin
            an_q  <= sel ? 2'b10 : 2'b01;
            seg_q <= decode(digit);
         end
`else
         an_q  <= sel ? 2'b10 : 2'b01;
         seg_q <= decode(digit);
`endif
      end
   end

   assign bus.seg      = seg_q;
   assign bus.an       = an_q;
   assign bus.tens     = tens_q;
   assign bus.overflow = overflow_q;
   assign bus.invalid  = invalid_q;
endmodule

// File: tb/tb_bcd_display_driver.sv
// Randomized self-checking bench for bcd_display_driver against a digit-level reference model.
module tb_bcd_display_driver;
   localparam int SCAN_DIV = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   bcd_display_if bus();

   bcd_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   logic [6:0] seg_tab [16];
   int         m_k;
   int         m_tens;
   int         m_prev;
   logic [6:0] exp_seg;
   logic [1:0] exp_an;
   logic       exp_ovf;
   logic       exp_inv;
   logic [14:0] exp_all;

   // Apply one clock edge and advance the reference model to what the outputs should be after it.
   task automatic drive(input int u, input bit r);
      int slot;
      bus.units_in = 4'(u);
      reset = r;
      @(posedge clk);
      if (r) begin
         m_k = 0; m_tens = 0; m_prev = 0;
         exp_seg = 7'h00; exp_an = 2'b00; exp_ovf = 1'b0; exp_inv = 1'b0;
      end else begin
         slot = (m_k / SCAN_DIV) % 2;
         exp_an  = (slot == 1) ? 2'b10 : 2'b01;
         exp_seg = (slot == 1) ? seg_tab[m_tens] : seg_tab[u];
`ifdef LEADING_ZERO_BLANK_EN
         if (slot == 1 && m_tens == 0) begin
            exp_an = 2'b00; exp_seg = 7'h00;
         end
`endif
         exp_ovf = 1'b0;
         if (m_prev == 9 && u == 0) begin
            m_tens = (m_tens + 1) % 10;
            exp_ovf = (m_tens == 0);
         end
         if (u > 9) exp_inv = 1'b1;
         m_prev = u;
         m_k++;
      end
      exp_all = {exp_seg, exp_an, 4'(m_tens), exp_ovf, exp_inv};
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(7, 1'b1);
         n_checks++;
         if ({bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 0000", {bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid});
         end
      end
      drive(7, 1'b0);
      n_checks++;
      if (bus.an !== 2'b01 || bus.seg !== 7'h07) begin
         n_fail++;
         $display("FAIL reset_first_edge: got an=%b seg=%h want an=01 seg=07", bus.an, bus.seg);
      end
   endtask

   task automatic test_scan();
      drive(5, 1'b1);
      for (int i = 0; i < 4 * SCAN_DIV; i++) begin
         drive(5, 1'b0);
         n_checks++;
         if ({bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid} !== exp_all) begin
            n_fail++;
            $display("FAIL scan cyc%0d: got %h want %h", i, {bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid}, exp_all);
         end
      end
   endtask

   task automatic test_count();
      int pulses = 0;
      drive(0, 1'b1);
      for (int i = 0; i < 101; i++) begin
         drive(i % 10, 1'b0);
         if (bus.overflow === 1'b1) pulses++;
         n_checks++;
         if ({bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid} !== exp_all) begin
            n_fail++;
            $display("FAIL count cyc%0d: got %h want %h", i, {bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid}, exp_all);
         end
      end
      n_checks++;
      if (pulses != 1 || bus.tens !== 4'd0) begin
         n_fail++;
         $display("FAIL overflow_once: got pulses=%0d tens=%0d want pulses=1 tens=0", pulses, bus.tens);
      end
   endtask

   task automatic test_no_increment();
      logic [3:0] t0;
      for (int i = 0; i < 10; i++) drive(i, 1'b0);
      t0 = bus.tens;
      drive(9, 1'b0);
      drive(3, 1'b0);
      for (int i = 0; i < 20; i++) begin
         drive(0, 1'b0);
         n_checks++;
         if (bus.tens !== t0 || bus.overflow !== 1'b0 || bus.seg !== exp_seg || bus.an !== exp_an) begin
            n_fail++;
            $display("FAIL no_increment cyc%0d: got tens=%0d ovf=%b seg=%h want tens=%0d ovf=0 seg=%h", i, bus.tens, bus.overflow, bus.seg, t0, exp_seg);
         end
      end
   endtask

   task automatic test_invalid();
      drive(5, 1'b1);
      drive(4'hC, 1'b0);
      n_checks++;
      if (bus.invalid !== 1'b1 || bus.seg !== 7'h40 || bus.an !== 2'b01) begin
         n_fail++;
         $display("FAIL invalid_dash: got inv=%b seg=%h an=%b want inv=1 seg=40 an=01", bus.invalid, bus.seg, bus.an);
      end
      for (int i = 0; i < 10; i++) begin
         drive(5, 1'b0);
         n_checks++;
         if ({bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid} !== exp_all || bus.invalid !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_sticky cyc%0d: got %h want %h", i, {bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid}, exp_all);
         end
      end
      drive(5, 1'b1);
      drive(5, 1'b0);
      n_checks++;
      if (bus.invalid !== 1'b0) begin
         n_fail++;
         $display("FAIL invalid_clear: got %b want 0", bus.invalid);
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      drive(0, 1'b1);
      for (int w = 0; w < 7; w++)
         for (int d = 0; d < 10; d++) drive(d, 1'b0);
      drive(0, 1'b0);
      n_checks++;
      if (bus.tens !== 4'd7) begin
         n_fail++;
         $display("FAIL reach_seven: got tens=%0d want 7", bus.tens);
      end
      while (((m_k / SCAN_DIV) % 2) != 1 && guard < 4 * SCAN_DIV) begin
         drive(0, 1'b0);
         guard++;
      end
      drive(0, 1'b0);
      drive(9, 1'b1);
      n_checks++;
      if ({bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid} !== 15'h0) begin
         n_fail++;
         $display("FAIL reset_mid: got %h want 0000", {bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid});
      end
      drive(9, 1'b0);
      drive(0, 1'b0);
      n_checks++;
      if (bus.tens !== 4'd1 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_count: got tens=%0d ovf=%b want tens=1 ovf=0", bus.tens, bus.overflow);
      end
   endtask

   task automatic test_random();
      int u = 0;
      drive(0, 1'b1);
      for (int i = 0; i < 600; i++) begin
         bit r;
         if ($urandom_range(0, 99) < 80) u = (m_prev + 1) % 10;
         else u = $urandom_range(0, 15);
         r = ($urandom_range(0, 199) == 0);
         drive(u, r);
         n_checks++;
         if ({bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid} !== exp_all) begin
            n_fail++;
            $display("FAIL random cyc%0d u=%0d: got %h want %h", i, u, {bus.seg, bus.an, bus.tens, bus.overflow, bus.invalid}, exp_all);
         end
      end
   endtask

   initial begin
      seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
      seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
      seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
      for (int i = 10; i < 16; i++) seg_tab[i] = 7'h40;
      m_k = 0; m_tens = 0; m_prev = 0;
      bus.units_in = 4'd7;
      @(negedge clk);
      test_reset();
      test_scan();
      test_count();
      test_no_increment();
      test_invalid();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
